// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and its bench scoreboard.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ADDR = 1'b1;

  localparam int unsigned CNT_W = 4;

  // Word-aligned and inside the array; depth is a power of two, so a limit compare suffices.
  function automatic logic dmem_addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = {2'b00, depth} << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; write-first, so a store echoes its data on rdata_o.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem[idx_i] <= wdata_i;
        rdata_o    <= wdata_i;
      end else begin
        rdata_o    <= mem[idx_i];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, acknowledged after LATENCY cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q;
  logic             accept, enter_resp;
  logic             cur_we, cur_ok;
  logic [31:0]      cur_addr, cur_wdata;
  logic             zero_q, err_q;
  logic [31:0]      arr_rdata;

  assign ready_o = (state_q == ST_IDLE);
  assign ack_o   = (state_q == ST_RESP);
  assign accept  = req_i & ready_o;

  always_comb begin
    state_d    = state_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = ST_WAIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the RESP-entry edge is the accept edge, so the live inputs are used there.
  assign cur_we    = (state_q == ST_IDLE) ? we_i    : we_q;
  assign cur_addr  = (state_q == ST_IDLE) ? addr_i  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? wdata_i : wdata_q;
  assign cur_ok    = dmem_addr_ok(cur_addr, DEPTH_WORDS);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= we_i;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      zero_q <= 1'b1;
      err_q  <= ERR_NONE;
    end else if (enter_resp) begin
      zero_q <= ~cur_ok;
      err_q  <= cur_ok ? ERR_NONE : ERR_ADDR;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (enter_resp & cur_ok),
    .we_i    (cur_we),
    .idx_i   (cur_addr[IDX_W+1:2]),
    .wdata_i (cur_wdata),
    .rdata_o (arr_rdata)
  );

  // The RAM output holds between accesses; zero_q masks it after reset and on errors.
  assign rdata_o = zero_q ? '0 : arr_rdata;
  assign err_o   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the pipeline's data-memory access path. It accepts one load or store request at a time from the CPU's MEM stage over a valid/ready handshake. After a programmable latency it returns a single-cycle acknowledge carrying read data and an error flag. It replaces the zero-latency combinational data memory, so the pipeline can be tested against realistic memory timing.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words stored. Must be a power of 2, at least 4.
- `LATENCY`, default 3: cycles from request acceptance to `ack_o`. Legal range is 1 to 15.
- `clk_i` in 1: the only clock; all logic is rising-edge.
- `rst_i` in 1: reset, asynchronous assert, active-low.
- `req_i` in 1: request valid.
- `we_i` in 1: 1 = store, 0 = load. Sampled with the request.
- `addr_i` in 32: byte address. Sampled with the request.
- `wdata_i` in 32: store data. Sampled with the request.
- `ready_o` out 1: the block can accept a request this cycle.
- `ack_o` out 1: one-cycle completion pulse.
- `rdata_o` out 32: load data. Valid while `ack_o` is high; holds its value until the next `ack_o`.
- `err_o` out 1: error status of the completing request. Valid with `ack_o`; holds its value until the next `ack_o`.

## Operation
- State machine with three states:
  - IDLE: `ready_o` = 1.
  - WAIT: counter running.
  - RESP: `ack_o` = 1.
- Accept condition: `req_i` & `ready_o` at a rising edge. On accept, capture `we_i`, `addr_i` and `wdata_i`, and load the counter with `LATENCY`-1.
- Transitions:
  - From IDLE: go to WAIT if `LATENCY` > 1, otherwise go straight to RESP.
  - From WAIT: decrement the counter each cycle. Move to RESP on the edge where the counter equals 1.
  - From RESP: always return to IDLE. Back-to-back accepts are therefore impossible; `ready_o` is low during RESP.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- Error conditions:
  - Misaligned: `addr[1:0]` != 0.
  - Out of range: `addr[31:log2(DEPTH_WORDS)+2]` != 0.
- Error response: no array write, `rdata_o` = 0, `err_o` = 1.
- Good store: the array word is written on the edge entering RESP. `rdata_o` = `wdata` (echo), `err_o` = 0.
- Good load: the array is read on the edge entering RESP. `rdata_o` = word, `err_o` = 0.
- `req_i` while `ready_o` = 0 is ignored, with no side effects. The requester must hold `req_i` until it sees `ready_o`.
- Inputs other than `req_i` are don't-care outside the accept cycle.
- The array is not reset. Its contents are undefined until written.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `ready_o` = 1, `ack_o` = 0, `rdata_o` = 0, `err_o` = 0.
- Accept at edge T gives `ack_o` high during cycle T+`LATENCY`, then `ready_o` high from cycle T+`LATENCY`+1.
- Request throughput: one request per `LATENCY`+1 cycles.
- Reset mid-operation aborts the request immediately. A store aborted before the RESP-entry edge never reaches the array. A store whose RESP-entry edge has already occurred stays committed.
- Read-after-write: a load accepted after a store's `ack_o` returns the stored value.
- Reset release: the first accept can occur on the first rising edge with `rst_i` = 1.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - the `ERR_NONE`/`ERR_ADDR` constants;
  - a helper function `dmem_addr_ok(addr, depth)` for reuse by the bench scoreboard.
- Sub-module `dmem_array`: single-port synchronous word RAM (`DEPTH_WORDS` x 32) with we/idx/wdata/rdata. The FSM and counter stay in `dmem_responder`.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 with `LATENCY`=3, then load 0x10.
  - Store: `ack_o` 3 cycles after accept, `err_o`=0.
  - Load: `rdata_o`=0xDEADBEEF, `err_o`=0.
- Load from 0x13 (misaligned) and from 0x400 with `DEPTH_WORDS`=256.
  - Both: `ack_o` with `err_o`=1 and `rdata_o`=0.
  - A subsequent load of word 0 returns its prior value unchanged.
- `LATENCY`=1: hold `req_i` high continuously with alternating stores and loads.
  - Accepts occur every 2 cycles.
  - Each `ack_o` lasts exactly 1 cycle.
  - `ready_o` pattern is 1,0,1,0.
- Drive `req_i` during WAIT and RESP with a different address.
  - The request is ignored.
  - The captured request completes with its own data.
- Assert `rst_i` low one cycle after accepting a store of 0x12345678 to 0x20 (old value 0x0), then release and load 0x20.
  - Returns 0x0.
  - Outputs return to their reset values asynchronously.
- Store to the last word (0x3FC), then to 0x0.
  - Both loads read back correctly.
  - No aliasing between the two words.
